// File: rtl/game_sprite_motion_if.sv
// Control/status bundle between game logic (master) and the sprite motion engine (slave).
// Carries the hit counter signals only when GAME_SPRITE_HIT_COUNT_EN is defined.
interface game_sprite_motion_if #(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 10,
  parameter int DX_WIDTH = 4,
  parameter int DY_WIDTH = 4
) ();
  logic                i_write_xy;
  logic [X_WIDTH-1:0]  i_write_x;
  logic [Y_WIDTH-1:0]  i_write_y;
  logic                i_write_dxy;
  logic [DX_WIDTH-1:0] i_write_dx;
  logic [DY_WIDTH-1:0] i_write_dy;
  logic [1:0]          i_mode;
  logic                i_enable_update;
  logic [X_WIDTH-1:0]  o_sprite_x;
  logic [Y_WIDTH-1:0]  o_sprite_y;
  logic [DX_WIDTH-1:0] o_sprite_dx;
  logic [DY_WIDTH-1:0] o_sprite_dy;
  logic                o_moved;
  logic                o_hit_x;
  logic                o_hit_y;
`ifdef GAME_SPRITE_HIT_COUNT_EN
  logic                i_hit_count_clear;
  logic [7:0]          o_hit_count;
`endif

`ifdef GAME_SPRITE_HIT_COUNT_EN
  modport master (
    output i_write_xy, i_write_x, i_write_y, i_write_dxy, i_write_dx, i_write_dy,
           i_mode, i_enable_update, i_hit_count_clear,
    input  o_sprite_x, o_sprite_y, o_sprite_dx, o_sprite_dy, o_moved, o_hit_x, o_hit_y,
           o_hit_count
  );
  modport slave (
    input  i_write_xy, i_write_x, i_write_y, i_write_dxy, i_write_dx, i_write_dy,
           i_mode, i_enable_update, i_hit_count_clear,
    output o_sprite_x, o_sprite_y, o_sprite_dx, o_sprite_dy, o_moved, o_hit_x, o_hit_y,
           o_hit_count
  );
`else
  modport master (
    output i_write_xy, i_write_x, i_write_y, i_write_dxy, i_write_dx, i_write_dy,
           i_mode, i_enable_update,
    input  o_sprite_x, o_sprite_y, o_sprite_dx, o_sprite_dy, o_moved, o_hit_x, o_hit_y
  );
  modport slave (
    input  i_write_xy, i_write_x, i_write_y, i_write_dxy, i_write_dx, i_write_dy,
           i_mode, i_enable_update,
    output o_sprite_x, o_sprite_y, o_sprite_dx, o_sprite_dy, o_moved, o_hit_x, o_hit_y
  );
`endif
endinterface

// File: rtl/game_sprite_motion.sv
// Sprite position/velocity engine with per-update edge policy (free, wrap, bounce, stop).
// Optional saturating hit counter enabled by defining GAME_SPRITE_HIT_COUNT_EN.
module game_sprite_motion #(
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 10,
  parameter int DX_WIDTH     = 4,
  parameter int DY_WIDTH     = 4,
  parameter int STROBE_WIDTH = 20,
  parameter int X_LIMIT      = 639,
  parameter int Y_LIMIT      = 479
) (
  input logic                clk,
  input logic                reset,
  game_sprite_motion_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_FREE   = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_STOP   = 2'b11
  } mode_e;

  localparam int XN = X_WIDTH + 2;
  localparam int YN = Y_WIDTH + 2;
  localparam logic signed [XN-1:0] XLIM  = XN'(X_LIMIT);
  localparam logic signed [XN-1:0] XSPAN = XN'(X_LIMIT + 1);
  localparam logic signed [YN-1:0] YLIM  = YN'(Y_LIMIT);
  localparam logic signed [YN-1:0] YSPAN = YN'(Y_LIMIT + 1);
  localparam logic [X_WIDTH-1:0]   XMAX  = X_WIDTH'(X_LIMIT);
  localparam logic [Y_WIDTH-1:0]   YMAX  = Y_WIDTH'(Y_LIMIT);
  localparam logic [DX_WIDTH-1:0]  DXMIN = {1'b1, {(DX_WIDTH-1){1'b0}}};
  localparam logic [DX_WIDTH-1:0]  DXMAX = {1'b0, {(DX_WIDTH-1){1'b1}}};
  localparam logic [DY_WIDTH-1:0]  DYMIN = {1'b1, {(DY_WIDTH-1){1'b0}}};
  localparam logic [DY_WIDTH-1:0]  DYMAX = {1'b0, {(DY_WIDTH-1){1'b1}}};
  localparam logic [STROBE_WIDTH-1:0] STROBE_ONE = STROBE_WIDTH'(1);

  logic [STROBE_WIDTH-1:0] r_strobeCnt;
  logic [X_WIDTH-1:0]      r_x;
  logic [Y_WIDTH-1:0]      r_y;
  logic [DX_WIDTH-1:0]     r_dx;
  logic [DY_WIDTH-1:0]     r_dy;
  logic                    r_moved, r_hitX, r_hitY;

  logic                    w_strobe, w_update;
  mode_e                   w_mode;
  logic signed [XN-1:0]    w_xSum, w_xWrapped;
  logic signed [YN-1:0]    w_ySum, w_yWrapped;
  logic                    w_xUnder, w_xOver, w_xHit, w_yUnder, w_yOver, w_yHit;
  logic [X_WIDTH-1:0]      w_xMove, w_xWrite;
  logic [Y_WIDTH-1:0]      w_yMove, w_yWrite;
  logic [DX_WIDTH-1:0]     w_dxMove;
  logic [DY_WIDTH-1:0]     w_dyMove;

  assign w_strobe = &r_strobeCnt;
  assign w_update = bus.i_enable_update && w_strobe && !bus.i_write_xy;
  assign w_mode   = mode_e'(bus.i_mode);

  // X axis: widen to signed so under/overflow is visible, then apply the edge policy.
  always_comb begin
    w_xSum     = $signed({2'b00, r_x}) + $signed({{(XN-DX_WIDTH){r_dx[DX_WIDTH-1]}}, r_dx});
    w_xUnder   = w_xSum[XN-1];
    w_xOver    = !w_xUnder && (w_xSum > XLIM);
    w_xHit     = (w_mode != MODE_FREE) && (w_xUnder || w_xOver);
    w_xWrapped = w_xSum;
    if (w_mode == MODE_WRAP) begin
      if (w_xOver)       w_xWrapped = w_xSum - XSPAN;
      else if (w_xUnder) w_xWrapped = w_xSum + XSPAN;
    end
    if (w_mode == MODE_FREE)   w_xMove = w_xSum[X_WIDTH-1:0];
    else if (w_xWrapped[XN-1]) w_xMove = '0;
    else if (w_xWrapped > XLIM) w_xMove = XMAX;
    else                       w_xMove = w_xWrapped[X_WIDTH-1:0];
    w_dxMove = r_dx;
    if (w_xHit && w_mode == MODE_BOUNCE) w_dxMove = (r_dx == DXMIN) ? DXMAX : -r_dx;
    else if (w_xHit && w_mode == MODE_STOP) w_dxMove = '0;
    w_xWrite = (w_mode != MODE_FREE && bus.i_write_x > XMAX) ? XMAX : bus.i_write_x;
  end

  always_comb begin
    w_ySum     = $signed({2'b00, r_y}) + $signed({{(YN-DY_WIDTH){r_dy[DY_WIDTH-1]}}, r_dy});
    w_yUnder   = w_ySum[YN-1];
    w_yOver    = !w_yUnder && (w_ySum > YLIM);
    w_yHit     = (w_mode != MODE_FREE) && (w_yUnder || w_yOver);
    w_yWrapped = w_ySum;
    if (w_mode == MODE_WRAP) begin
      if (w_yOver)       w_yWrapped = w_ySum - YSPAN;
      else if (w_yUnder) w_yWrapped = w_ySum + YSPAN;
    end
    if (w_mode == MODE_FREE)   w_yMove = w_ySum[Y_WIDTH-1:0];
    else if (w_yWrapped[YN-1]) w_yMove = '0;
    else if (w_yWrapped > YLIM) w_yMove = YMAX;
    else                       w_yMove = w_yWrapped[Y_WIDTH-1:0];
    w_dyMove = r_dy;
    if (w_yHit && w_mode == MODE_BOUNCE) w_dyMove = (r_dy == DYMIN) ? DYMAX : -r_dy;
    else if (w_yHit && w_mode == MODE_STOP) w_dyMove = '0;
    w_yWrite = (w_mode != MODE_FREE && bus.i_write_y > YMAX) ? YMAX : bus.i_write_y;
  end

  // Host writes take priority over motion on their own register pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_strobeCnt <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_moved     <= 1'b0;
      r_hitX      <= 1'b0;
      r_hitY      <= 1'b0;
    end else begin
      r_strobeCnt <= r_strobeCnt + STROBE_ONE;
      r_moved     <= w_update;
      r_hitX      <= w_update && w_xHit;
      r_hitY      <= w_update && w_yHit;
      if (bus.i_write_xy) begin
        r_x <= w_xWrite;
        r_y <= w_yWrite;
      end else if (w_update) begin
        r_x <= w_xMove;
        r_y <= w_yMove;
      end
      if (bus.i_write_dxy) begin
        r_dx <= bus.i_write_dx;
        r_dy <= bus.i_write_dy;
      end else if (w_update) begin
        r_dx <= w_dxMove;
        r_dy <= w_dyMove;
      end
    end
  end

`ifdef GAME_SPRITE_HIT_COUNT_EN
  logic [7:0] r_hitCount;

  always_ff @(posedge clk) begin
    if (!reset || bus.i_hit_count_clear) r_hitCount <= 8'd0;
    else if (w_update && (w_xHit || w_yHit) && r_hitCount != 8'hFF) r_hitCount <= r_hitCount + 8'd1;
  end

  assign bus.o_hit_count = r_hitCount;
`endif

  assign bus.o_sprite_x  = r_x;
  assign bus.o_sprite_y  = r_y;
  assign bus.o_sprite_dx = r_dx;
  assign bus.o_sprite_dy = r_dy;
  assign bus.o_moved     = r_moved;
  assign bus.o_hit_x     = r_hitX;
  assign bus.o_hit_y     = r_hitY;
endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion with a 4-cycle update strobe and a 16x8 screen.
module tb_game_sprite_motion;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tbCnt = 0;
  int   errors = 0;
  int   checks = 0;

  game_sprite_motion_if #(.X_WIDTH(5), .Y_WIDTH(5), .DX_WIDTH(3), .DY_WIDTH(3)) bus ();

  game_sprite_motion #(
    .X_WIDTH(5), .Y_WIDTH(5), .DX_WIDTH(3), .DY_WIDTH(3),
    .STROBE_WIDTH(2), .X_LIMIT(15), .Y_LIMIT(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Expected strobe phase: the update edge is the one that follows a cycle with phase 3.
  always @(posedge clk) begin
    if (!reset) tbCnt <= 0;
    else        tbCnt <= (tbCnt + 1) % 4;
  end

  task automatic clearDrive();
    bus.i_enable_update = 1'b0;
    bus.i_write_xy      = 1'b0;
    bus.i_write_dxy     = 1'b0;
  endtask

  task automatic setMode(input logic [1:0] m);
    @(negedge clk); clearDrive(); bus.i_mode = m;
  endtask

  task automatic writeState(input logic doXy, input logic [4:0] x, input logic [4:0] y,
                            input logic doDxy, input logic [2:0] dx, input logic [2:0] dy);
    @(negedge clk); clearDrive();
    bus.i_write_xy = doXy; bus.i_write_x = x; bus.i_write_y = y;
    bus.i_write_dxy = doDxy; bus.i_write_dx = dx; bus.i_write_dy = dy;
    @(negedge clk); clearDrive();
  endtask

  task automatic alignToStrobe();
    @(negedge clk); clearDrive();
    for (int i = 0; i < 8; i++) begin
      if (tbCnt == 3) break;
      @(negedge clk); clearDrive();
    end
  endtask

  task automatic doUpdate();
    alignToStrobe();
    bus.i_enable_update = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic nextCycle();
    @(negedge clk); clearDrive();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic sawMoved;
    bus.i_write_xy = 1'b1; bus.i_write_x = 5'd5; bus.i_write_y = 5'd3;
    bus.i_write_dxy = 1'b1; bus.i_write_dx = 3'd2; bus.i_write_dy = 3'd1;
    bus.i_enable_update = 1'b1; bus.i_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_sprite_x !== 5'd0) begin errors++; $display("[TB] FAIL reset_x: got %0d want 0", bus.o_sprite_x); end
    checks++; if (bus.o_sprite_y !== 5'd0) begin errors++; $display("[TB] FAIL reset_y: got %0d want 0", bus.o_sprite_y); end
    checks++; if (bus.o_sprite_dx !== 3'd0 || bus.o_sprite_dy !== 3'd0) begin errors++; $display("[TB] FAIL reset_d: got dx=%0d dy=%0d want 0 0", bus.o_sprite_dx, bus.o_sprite_dy); end
    checks++; if ({bus.o_moved, bus.o_hit_x, bus.o_hit_y} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 000", {bus.o_moved, bus.o_hit_x, bus.o_hit_y}); end
    @(negedge clk); clearDrive(); reset = 1'b1;
    writeState(1'b0, 5'd0, 5'd0, 1'b1, 3'd1, 3'd1);
    sawMoved = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.o_moved) sawMoved = 1'b1;
    end
    checks++; if (sawMoved !== 1'b0) begin errors++; $display("[TB] FAIL disabled_moved: got %b want 0", sawMoved); end
    checks++; if (bus.o_sprite_x !== 5'd0 || bus.o_sprite_y !== 5'd0) begin errors++; $display("[TB] FAIL disabled_pos: got x=%0d y=%0d want 0 0", bus.o_sprite_x, bus.o_sprite_y); end
    checks++; if (bus.o_sprite_dx !== 3'd1) begin errors++; $display("[TB] FAIL disabled_dx: got %0d want 1", bus.o_sprite_dx); end
  endtask

  task automatic test_free();
    setMode(2'b00);
    writeState(1'b1, 5'd30, 5'd0, 1'b1, 3'd3, 3'd0);
    doUpdate();
    checks++; if (bus.o_sprite_x !== 5'd1) begin errors++; $display("[TB] FAIL free_x: got %0d want 1", bus.o_sprite_x); end
    checks++; if ({bus.o_moved, bus.o_hit_x} !== 2'b10) begin errors++; $display("[TB] FAIL free_pulses: got moved,hit_x=%b want 10", {bus.o_moved, bus.o_hit_x}); end
    nextCycle();
    checks++; if (bus.o_moved !== 1'b0 || bus.o_sprite_x !== 5'd1) begin errors++; $display("[TB] FAIL free_after: got moved=%b x=%0d want 0 1", bus.o_moved, bus.o_sprite_x); end
  endtask

  task automatic test_wrap();
    setMode(2'b01);
    writeState(1'b1, 5'd14, 5'd1, 1'b1, 3'd3, 3'b110);
    doUpdate();
    checks++; if (bus.o_sprite_x !== 5'd1) begin errors++; $display("[TB] FAIL wrap_x: got %0d want 1", bus.o_sprite_x); end
    checks++; if (bus.o_sprite_y !== 5'd7) begin errors++; $display("[TB] FAIL wrap_y: got %0d want 7", bus.o_sprite_y); end
    checks++; if ({bus.o_hit_x, bus.o_hit_y} !== 2'b11) begin errors++; $display("[TB] FAIL wrap_hits: got %b want 11", {bus.o_hit_x, bus.o_hit_y}); end
    nextCycle();
    checks++; if ({bus.o_hit_x, bus.o_hit_y} !== 2'b00) begin errors++; $display("[TB] FAIL wrap_hit_width: got %b want 00", {bus.o_hit_x, bus.o_hit_y}); end
  endtask

  task automatic test_bounce();
    setMode(2'b10);
    writeState(1'b1, 5'd14, 5'd0, 1'b1, 3'd3, 3'd0);
    doUpdate();
    checks++; if (bus.o_sprite_x !== 5'd15 || bus.o_sprite_dx !== 3'b101) begin errors++; $display("[TB] FAIL bounce_edge: got x=%0d dx=%b want 15 101", bus.o_sprite_x, bus.o_sprite_dx); end
    checks++; if ({bus.o_hit_x, bus.o_hit_y} !== 2'b10) begin errors++; $display("[TB] FAIL bounce_hits: got %b want 10", {bus.o_hit_x, bus.o_hit_y}); end
    doUpdate();
    checks++; if (bus.o_sprite_x !== 5'd12 || bus.o_hit_x !== 1'b0) begin errors++; $display("[TB] FAIL bounce_return: got x=%0d hit_x=%b want 12 0", bus.o_sprite_x, bus.o_hit_x); end
    writeState(1'b1, 5'd1, 5'd0, 1'b1, 3'b100, 3'd0);
    doUpdate();
    checks++; if (bus.o_sprite_x !== 5'd0 || bus.o_sprite_dx !== 3'b011) begin errors++; $display("[TB] FAIL bounce_minneg: got x=%0d dx=%b want 0 011", bus.o_sprite_x, bus.o_sprite_dx); end
    checks++; if (bus.o_hit_x !== 1'b1) begin errors++; $display("[TB] FAIL bounce_minneg_hit: got %b want 1", bus.o_hit_x); end
  endtask

  task automatic test_stop();
    setMode(2'b11);
    writeState(1'b1, 5'd0, 5'd6, 1'b1, 3'd0, 3'd2);
    doUpdate();
    checks++; if (bus.o_sprite_y !== 5'd7 || bus.o_sprite_dy !== 3'd0) begin errors++; $display("[TB] FAIL stop_edge: got y=%0d dy=%0d want 7 0", bus.o_sprite_y, bus.o_sprite_dy); end
    checks++; if ({bus.o_hit_x, bus.o_hit_y} !== 2'b01) begin errors++; $display("[TB] FAIL stop_hits: got %b want 01", {bus.o_hit_x, bus.o_hit_y}); end
    doUpdate();
    checks++; if (bus.o_sprite_y !== 5'd7 || {bus.o_moved, bus.o_hit_y} !== 2'b10) begin errors++; $display("[TB] FAIL stop_hold: got y=%0d moved,hit_y=%b want 7 10", bus.o_sprite_y, {bus.o_moved, bus.o_hit_y}); end
  endtask

  task automatic test_zero_velocity();
    setMode(2'b01);
    writeState(1'b1, 5'd5, 5'd3, 1'b1, 3'd0, 3'd0);
    doUpdate();
    checks++; if ({bus.o_moved, bus.o_hit_x, bus.o_hit_y} !== 3'b100) begin errors++; $display("[TB] FAIL zero_pulses: got %b want 100", {bus.o_moved, bus.o_hit_x, bus.o_hit_y}); end
    checks++; if (bus.o_sprite_x !== 5'd5 || bus.o_sprite_y !== 5'd3) begin errors++; $display("[TB] FAIL zero_pos: got x=%0d y=%0d want 5 3", bus.o_sprite_x, bus.o_sprite_y); end
  endtask

  task automatic test_write_clamp();
    setMode(2'b01);
    writeState(1'b1, 5'd20, 5'd31, 1'b0, 3'd0, 3'd0);
    checks++; if (bus.o_sprite_x !== 5'd15 || bus.o_sprite_y !== 5'd7) begin errors++; $display("[TB] FAIL clamp_write: got x=%0d y=%0d want 15 7", bus.o_sprite_x, bus.o_sprite_y); end
    setMode(2'b00);
    writeState(1'b1, 5'd20, 5'd31, 1'b0, 3'd0, 3'd0);
    checks++; if (bus.o_sprite_x !== 5'd20 || bus.o_sprite_y !== 5'd31) begin errors++; $display("[TB] FAIL free_write: got x=%0d y=%0d want 20 31", bus.o_sprite_x, bus.o_sprite_y); end
    // Out-of-range position left over from FREE is pulled back into range by BOUNCE.
    writeState(1'b0, 5'd0, 5'd0, 1'b1, 3'd1, 3'd0);
    setMode(2'b10);
    doUpdate();
    checks++; if (bus.o_sprite_x !== 5'd15 || bus.o_sprite_y !== 5'd7) begin errors++; $display("[TB] FAIL leftover_pos: got x=%0d y=%0d want 15 7", bus.o_sprite_x, bus.o_sprite_y); end
    checks++; if (bus.o_sprite_dx !== 3'b111 || {bus.o_hit_x, bus.o_hit_y} !== 2'b11) begin errors++; $display("[TB] FAIL leftover_dx_hits: got dx=%b hits=%b want 111 11", bus.o_sprite_dx, {bus.o_hit_x, bus.o_hit_y}); end
  endtask

  task automatic test_back_to_back();
    setMode(2'b00);
    writeState(1'b1, 5'd3, 5'd0, 1'b1, 3'd1, 3'd0);
    alignToStrobe();
    bus.i_enable_update = 1'b1;
    bus.i_write_xy = 1'b1; bus.i_write_x = 5'd9; bus.i_write_y = 5'd2;
    @(posedge clk); #1;
    checks++; if (bus.o_sprite_x !== 5'd9 || bus.o_sprite_y !== 5'd2 || bus.o_moved !== 1'b0) begin errors++; $display("[TB] FAIL xy_collision: got x=%0d y=%0d moved=%b want 9 2 0", bus.o_sprite_x, bus.o_sprite_y, bus.o_moved); end
    writeState(1'b1, 5'd2, 5'd0, 1'b1, 3'd2, 3'd0);
    alignToStrobe();
    bus.i_enable_update = 1'b1;
    bus.i_write_dxy = 1'b1; bus.i_write_dx = 3'd1; bus.i_write_dy = 3'd0;
    @(posedge clk); #1;
    checks++; if (bus.o_sprite_x !== 5'd4 || bus.o_sprite_dx !== 3'd1 || bus.o_moved !== 1'b1) begin errors++; $display("[TB] FAIL dxy_collision: got x=%0d dx=%0d moved=%b want 4 1 1", bus.o_sprite_x, bus.o_sprite_dx, bus.o_moved); end
    setMode(2'b10);
    writeState(1'b1, 5'd14, 5'd0, 1'b1, 3'd3, 3'd0);
    alignToStrobe();
    bus.i_enable_update = 1'b1;
    bus.i_write_dxy = 1'b1; bus.i_write_dx = 3'd2; bus.i_write_dy = 3'd0;
    @(posedge clk); #1;
    checks++; if (bus.o_sprite_x !== 5'd15 || bus.o_sprite_dx !== 3'd2 || bus.o_hit_x !== 1'b1) begin errors++; $display("[TB] FAIL bounce_dxy_collision: got x=%0d dx=%0d hit_x=%b want 15 2 1", bus.o_sprite_x, bus.o_sprite_dx, bus.o_hit_x); end
  endtask

`ifdef GAME_SPRITE_HIT_COUNT_EN
  task automatic test_hit_count();
    setMode(2'b10);
    writeState(1'b1, 5'd15, 5'd0, 1'b1, 3'd1, 3'd0);
    @(negedge clk); bus.i_hit_count_clear = 1'b1;
    @(negedge clk); bus.i_hit_count_clear = 1'b0;
    checks++; if (bus.o_hit_count !== 8'd0) begin errors++; $display("[TB] FAIL count_clear: got %0d want 0", bus.o_hit_count); end
    bus.i_enable_update = 1'b1;
    bus.i_write_dxy = 1'b1; bus.i_write_dx = 3'd1; bus.i_write_dy = 3'd0;
    repeat (1210) @(negedge clk);
    checks++; if (bus.o_hit_count !== 8'd255) begin errors++; $display("[TB] FAIL count_saturate: got %0d want 255", bus.o_hit_count); end
    bus.i_hit_count_clear = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.o_hit_count !== 8'd0) begin errors++; $display("[TB] FAIL count_clear_wins: got %0d want 0", bus.o_hit_count); end
    bus.i_hit_count_clear = 1'b0;
    clearDrive();
  endtask
`endif

  initial begin
    clearDrive();
    bus.i_write_x = '0; bus.i_write_y = '0; bus.i_write_dx = '0; bus.i_write_dy = '0;
    bus.i_mode = 2'b00;
`ifdef GAME_SPRITE_HIT_COUNT_EN
    bus.i_hit_count_clear = 1'b0;
`endif
    test_reset();
    test_free();
    test_wrap();
    test_bounce();
    test_stop();
    test_zero_velocity();
    test_write_clamp();
    test_back_to_back();
`ifdef GAME_SPRITE_HIT_COUNT_EN
    test_hit_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
